// File: rtl/bios_loader_pkg.sv
// Shared types and constants for the UART boot loader.
package bios_loader_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StCheck,
        StDone,
        StError
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/bios_loader_word_asm.sv
// Packs bytes MSB-first into 32-bit words; word_valid_o pulses the cycle after the 4th byte.
module bios_loader_word_asm
    import bios_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [1:0]        byte_cnt_o,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o
);

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              valid_q, valid_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_valid_i) begin
            shift_d = {shift_q[WORD_W-BYTE_W-1:0], byte_i};
            cnt_d   = cnt_q + 2'd1;
            valid_d = (cnt_q == 2'd3);
        end
    end

    always_ff @(posedge clk_i) begin
        shift_q <= shift_d;
        cnt_q   <= cnt_d;
        valid_q <= valid_d;
    end

    assign byte_cnt_o   = cnt_q;
    assign word_o       = shift_q;
    assign word_valid_o = valid_q;

endmodule

// File: rtl/bios_loader.sv
// UART boot loader: frames length, data words and checksum, writing each word as it completes.
module bios_loader
    import bios_loader_pkg::*;
#(
    parameter int unsigned DEPTH          = 64,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk_auto,
    input  logic              reset,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              wr_en,
    output logic [WORD_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        error_code
);

    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       idx_q, idx_d;
    logic [BYTE_W-1:0] sum_q, sum_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic [1:0]        err_q, err_d;

    logic              busy_s, start_ok, timeout, last_byte, asm_clear;
    logic [15:0]       len_new;
    logic [1:0]        byte_cnt;
    logic [WORD_W-1:0] word;
    logic              word_valid;

    assign busy_s    = (state_q == StLenHi) || (state_q == StLenLo) ||
                       (state_q == StData)  || (state_q == StCheck);
    assign start_ok  = start && !busy_s;
    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout   = busy_s && !rx_valid && (idle_q == IdleW'(TIMEOUT_CYCLES - 1));
    assign len_new   = {len_q[15:8], rx_data};
    assign last_byte = rx_valid && (byte_cnt == 2'd3) && (idx_q == len_q - 16'd1);
    assign asm_clear = reset || start_ok;

    bios_loader_word_asm u_word_asm (
        .clk_i        (clk_auto),
        .clear_i      (asm_clear),
        .byte_valid_i (rx_valid && (state_q == StData)),
        .byte_i       (rx_data),
        .byte_cnt_o   (byte_cnt),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_ff @(posedge clk_auto) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start_ok) state_d = StLenHi;
            end
            StLenHi: begin
                if (rx_valid)     state_d = StLenLo;
                else if (timeout) state_d = StError;
            end
            StLenLo: begin
                if (rx_valid) begin
                    if (32'(len_new) > DEPTH) state_d = StError;
                    else if (len_new == '0)   state_d = StCheck;
                    else                      state_d = StData;
                end else if (timeout) begin
                    state_d = StError;
                end
            end
            StData: begin
                if (last_byte)    state_d = StCheck;
                else if (timeout) state_d = StError;
            end
            StCheck: begin
                if (rx_valid)     state_d = (rx_data == sum_q) ? StDone : StError;
                else if (timeout) state_d = StError;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        len_d  = len_q;
        idx_d  = idx_q;
        sum_d  = sum_q;
        idle_d = idle_q;
        err_d  = err_q;
        if (word_valid) idx_d = idx_q + 16'd1;
        if (start_ok) begin
            len_d  = '0;
            idx_d  = '0;
            sum_d  = '0;
            idle_d = '0;
            err_d  = ERR_NONE;
        end else if (busy_s) begin
            idle_d = rx_valid ? '0 : idle_q + 1'b1;
            if (rx_valid && (state_q != StCheck)) sum_d = sum_q + rx_data;
            if (rx_valid && (state_q == StLenHi)) len_d[15:8] = rx_data;
            if (rx_valid && (state_q == StLenLo)) begin
                len_d = len_new;
                if (32'(len_new) > DEPTH) err_d = ERR_LEN;
            end
            if (rx_valid && (state_q == StCheck) && (rx_data != sum_q)) err_d = ERR_CSUM;
            if (timeout) err_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk_auto) begin
        if (reset) begin
            len_q  <= '0;
            idx_q  <= '0;
            sum_q  <= '0;
            idle_q <= '0;
            err_q  <= ERR_NONE;
        end else begin
            len_q  <= len_d;
            idx_q  <= idx_d;
            sum_q  <= sum_d;
            idle_q <= idle_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        busy       = busy_s;
        done       = (state_q == StDone);
        error      = (state_q == StError);
        error_code = err_q;
        wr_en      = word_valid;
        wr_data    = word_valid ? word : '0;
        wr_addr    = word_valid ? (32'(BASE_ADDR) + 32'(idx_q)) : '0;
    end

endmodule

// File: tb/tb_bios_loader.sv
// Randomized self-checking bench for bios_loader; two instances differ only in BASE_ADDR.
module tb_bios_loader;

    logic        clk_auto = 1'b0;
    logic        reset, start, rx_valid;
    logic [7:0]  rx_data;

    logic        wr_en_a, busy_a, done_a, error_a;
    logic [31:0] wr_addr_a, wr_data_a;
    logic [1:0]  error_code_a;
    logic        wr_en_b, busy_b, done_b, error_b;
    logic [31:0] wr_addr_b, wr_data_b;
    logic [1:0]  error_code_b;

    bios_loader #(.DEPTH(64), .BASE_ADDR(0), .TIMEOUT_CYCLES(100)) dut_a (
        .clk_auto   (clk_auto),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .wr_en      (wr_en_a),
        .wr_addr    (wr_addr_a),
        .wr_data    (wr_data_a),
        .busy       (busy_a),
        .done       (done_a),
        .error      (error_a),
        .error_code (error_code_a)
    );

    bios_loader #(.DEPTH(64), .BASE_ADDR(16), .TIMEOUT_CYCLES(100)) dut_b (
        .clk_auto   (clk_auto),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .wr_en      (wr_en_b),
        .wr_addr    (wr_addr_b),
        .wr_data    (wr_data_b),
        .busy       (busy_b),
        .done       (done_b),
        .error      (error_b),
        .error_code (error_code_b)
    );

    always #5 clk_auto = ~clk_auto;

    typedef struct {
        int          t;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    wr_t         got_a[$];
    wr_t         got_b[$];
    logic [7:0]  frm[$];
    int          strobe_t[$];
    int          start_at = -1;

    always @(posedge clk_auto) cyc = cyc + 1;

    always @(negedge clk_auto) begin
        if (wr_en_a) got_a.push_back('{t: cyc, addr: wr_addr_a, data: wr_data_a});
        if (wr_en_b) got_b.push_back('{t: cyc, addr: wr_addr_b, data: wr_data_b});
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_auto);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        strobe_t.push_back(cyc);
        @(negedge clk_auto);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat ($urandom_range(1, 3)) @(negedge clk_auto);
    endtask

    task automatic clear_logs();
        got_a.delete();
        got_b.delete();
        strobe_t.delete();
    endtask

    task automatic run_frame();
        clear_logs();
        pulse_start();
        foreach (frm[i]) begin
            send_byte(frm[i]);
            if (i == start_at) pulse_start();
        end
        repeat (3) @(negedge clk_auto);
    endtask

    // Reference: length N, data words, mod-256 checksum; each word lands 1 cycle after its 4th byte.
    task automatic check_against_model(input string name);
        int         n, nw;
        logic [7:0] s;
        bit         done_e;
        logic [1:0] code_e;
        n = int'(frm[0]) * 256 + int'(frm[1]);
        if (n > 64) begin
            nw = 0; done_e = 1'b0; code_e = 2'd1;
        end else begin
            nw = n;
            s  = 8'h00;
            for (int i = 0; i < 2 + 4 * n; i++) s = s + frm[i];
            done_e = (frm[2 + 4 * n] == s);
            code_e = done_e ? 2'd0 : 2'd2;
        end
        checks++;
        if (got_a.size() != nw || got_b.size() != nw) begin
            errors++;
            $display("FAIL %s write_count: got %0d/%0d required %0d", name, got_a.size(),
                     got_b.size(), nw);
        end else begin
            for (int k = 0; k < nw; k++) begin
                logic [31:0] w;
                int          te;
                w  = {frm[2 + 4 * k], frm[3 + 4 * k], frm[4 + 4 * k], frm[5 + 4 * k]};
                te = strobe_t[5 + 4 * k] + 1;
                checks++;
                if (got_a[k].t !== te || got_a[k].addr !== 32'(k) || got_a[k].data !== w ||
                    got_b[k].addr !== 32'(16 + k) || got_b[k].data !== w) begin
                    errors++;
                    $display("FAIL %s write%0d: got t=%0d a=%h/%h d=%h/%h required t=%0d a=%h/%h d=%h",
                             name, k, got_a[k].t, got_a[k].addr, got_b[k].addr, got_a[k].data,
                             got_b[k].data, te, k, 16 + k, w);
                end
            end
        end
        checks++;
        if (done_a !== done_e || error_a !== !done_e || error_code_a !== code_e ||
            busy_a !== 1'b0 || done_b !== done_e || error_code_b !== code_e) begin
            errors++;
            $display("FAIL %s status: got done=%b err=%b code=%0d busy=%b required done=%b code=%0d",
                     name, done_a, error_a, error_code_a, busy_a, done_e, code_e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_auto);
        reset = 1'b0;
        @(negedge clk_auto);
        checks++;
        if ({wr_en_a, busy_a, done_a, error_a, error_code_a, wr_addr_a, wr_data_a} !== '0 ||
            {wr_en_b, busy_b, done_b, error_b, error_code_b, wr_addr_b, wr_data_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b addr_b=%h required all 0",
                     busy_a, done_a, error_a, wr_addr_b);
        end
    endtask

    task automatic test_single_word();
        frm = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h39};
        run_frame();
        check_against_model("single_word");
        checks++;
        if (got_a.size() != 1 || got_a[0].data !== 32'hDEADBEEF || done_a !== 1'b1) begin
            errors++;
            $display("FAIL single_word_literal: got n=%0d done=%b required 1 write of deadbeef",
                     got_a.size(), done_a);
        end
    endtask

    task automatic build_frame(input int n, input logic [31:0] w0, input logic [31:0] w1,
                               input bit rnd, input int csum_err);
        logic [7:0] s;
        frm = '{};
        frm.push_back(8'(n >> 8));
        frm.push_back(8'(n));
        for (int k = 0; k < n && n <= 64; k++) begin
            logic [31:0] w;
            w = rnd ? $urandom : ((k == 0) ? w0 : w1);
            for (int j = 3; j >= 0; j--) frm.push_back(8'(w >> (8 * j)));
        end
        if (n <= 64) begin
            s = 8'h00;
            foreach (frm[i]) s = s + frm[i];
            frm.push_back(s + 8'(csum_err));
        end
    endtask

    task automatic test_two_words();
        build_frame(2, 32'h68000001, 32'h30F78004, 1'b0, 0);
        run_frame();
        check_against_model("two_words");
    endtask

    task automatic test_len_too_big();
        frm = '{8'h00, 8'h41};
        run_frame();
        check_against_model("len_too_big");
    endtask

    task automatic test_bad_then_good();
        build_frame(1, 32'h12345678, 32'h0, 1'b0, 1);
        run_frame();
        check_against_model("bad_csum");
        build_frame(1, 32'hCAFEF00D, 32'h0, 1'b0, 0);
        run_frame();
        check_against_model("good_after_bad");
    endtask

    task automatic test_timeout();
        int t0;
        int guard;
        clear_logs();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        t0 = strobe_t[4];
        guard = 0;
        while (cyc < t0 + 100 && guard < 300) begin
            @(negedge clk_auto);
            guard++;
        end
        checks++;
        if (error_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: got err=%b busy=%b at cycle %0d required err=0 busy=1",
                     error_a, busy_a, cyc - t0);
        end
        @(negedge clk_auto);
        checks++;
        if (error_a !== 1'b1 || error_code_a !== 2'd3 || busy_a !== 1'b0 || got_a.size() != 0) begin
            errors++;
            $display("FAIL timeout_expire: got err=%b code=%0d writes=%0d required err=1 code=3 writes=0",
                     error_a, error_code_a, got_a.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b1;
        @(negedge clk_auto);
        reset = 1'b0;
        checks++;
        if ({wr_en_a, busy_a, done_a, error_a, error_code_a} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b err=%b code=%0d required all 0",
                     busy_a, done_a, error_a, error_code_a);
        end
        for (int i = 0; i < 6; i++) send_byte(8'(i + 1));
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || error_a !== 1'b0 || got_a.size() != 0) begin
            errors++;
            $display("FAIL ignore_rx_in_idle: got busy=%b done=%b err=%b writes=%0d required 0",
                     busy_a, done_a, error_a, got_a.size());
        end
        build_frame(1, 32'h0BADF00D, 32'h0, 1'b0, 0);
        run_frame();
        check_against_model("frame_after_reset");
    endtask

    task automatic test_zero_len();
        frm = '{8'h00, 8'h00, 8'h00};
        run_frame();
        check_against_model("zero_len");
    endtask

    task automatic test_start_mid_data();
        build_frame(2, 32'hA5A55A5A, 32'h01020304, 1'b0, 0);
        start_at = 5;
        run_frame();
        start_at = -1;
        check_against_model("start_mid_data");
    endtask

    task automatic test_random();
        for (int f = 0; f < 20; f++) begin
            int n;
            n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(65, 300)) :
                                               int'($urandom_range(0, 6));
            build_frame(n, 32'h0, 32'h0, 1'b1,
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 255)) : 0);
            run_frame();
            check_against_model($sformatf("random%0d", f));
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_single_word();
        test_two_words();
        test_len_too_big();
        test_bad_then_good();
        test_timeout();
        test_reset_mid();
        test_zero_len();
        test_start_mid_data();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
